// File: rtl/cacheline_adapter.sv
// Cache line adapter: turns one 256-bit line read or write from the cache
// into a four-beat 64-bit burst on the memory bus. When the burst is done it
// returns a single-cycle completion pulse to the cache.
//
// state    | meaning
// ---------+------------------------------------------------------------
// IDLE     | waiting for a cache request; write has priority over read
// RD_BURST | read_o high, one beat stored into line_o per resp_i cycle
// WR_BURST | write_o high, burst_o shows latched beat selected by counter
// DONE     | resp_o high for one cycle, requests ignored, back to IDLE
module cacheline_adapter #(
  parameter int LINE_W  = 256,
  parameter int BURST_W = 64,
  parameter int ADDR_W  = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               read_i,
  input  logic               write_i,
  input  logic [ADDR_W-1:0]  address_i,
  input  logic [LINE_W-1:0]  line_i,
  output logic [LINE_W-1:0]  line_o,
  output logic               resp_o,
  input  logic [BURST_W-1:0] burst_i,
  output logic [BURST_W-1:0] burst_o,
  output logic [ADDR_W-1:0]  address_o,
  output logic               read_o,
  output logic               write_o,
  input  logic               resp_i
);

  localparam int BEATS = LINE_W / BURST_W;
  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  // Mask that clears the byte-offset-within-line bits of an address.
  localparam logic [ADDR_W-1:0] LINE_MASK = ~(ADDR_W'(LINE_W / 8 - 1));

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RD_BURST = 2'd1,
    WR_BURST = 2'd2,
    DONE     = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [ADDR_W-1:0]  addr_q;
  logic [LINE_W-1:0]  wline_q;
  logic [LINE_W-1:0]  rline_q;
  logic               latch_wr;
  logic               latch_rd;
  logic               last_beat;

  assign last_beat = resp_i && (cnt_q == CNT_W'(BEATS - 1));

  // State and beat counter registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic, beat counting and Moore output decode.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    latch_wr = 1'b0;
    latch_rd = 1'b0;
    read_o   = 1'b0;
    write_o  = 1'b0;
    resp_o   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (write_i) begin
          latch_wr = 1'b1;
          cnt_d    = '0;
          state_d  = WR_BURST;
        end else if (read_i) begin
          latch_rd = 1'b1;
          cnt_d    = '0;
          state_d  = RD_BURST;
        end
      end
      RD_BURST: begin
        read_o = 1'b1;
        if (resp_i) cnt_d = cnt_q + 1'b1;
        if (last_beat) state_d = DONE;
      end
      WR_BURST: begin
        write_o = 1'b1;
        if (resp_i) cnt_d = cnt_q + 1'b1;
        if (last_beat) state_d = DONE;
      end
      DONE: begin
        resp_o  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Capture the line-aligned address and the write line when a request is accepted.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr_q  <= '0;
      wline_q <= '0;
    end else begin
      if (latch_wr || latch_rd) addr_q <= address_i & LINE_MASK;
      if (latch_wr) wline_q <= line_i;
    end
  end

  // Store each accepted read beat into its slot of the read line.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rline_q <= '0;
    end else if (state_q == RD_BURST && resp_i) begin
      for (int k = 0; k < BEATS; k++) begin
        if (cnt_q == CNT_W'(k)) rline_q[k*BURST_W +: BURST_W] <= burst_i;
      end
    end
  end

  // Select the write beat from the latched line; drive zero outside a write burst.
  always_comb begin
    burst_o = '0;
    if (state_q == WR_BURST) begin
      for (int k = 0; k < BEATS; k++) begin
        if (cnt_q == CNT_W'(k)) burst_o = wline_q[k*BURST_W +: BURST_W];
      end
    end
  end

  assign address_o = addr_q;
  assign line_o    = rline_q;

endmodule

// File: tb/tb_cacheline_adapter.sv
// Directed bench for cacheline_adapter: reads, gapped writes, simultaneous
// requests, mid-burst input changes, reset abort and stray resp_i.
module tb_cacheline_adapter;

  logic         clk = 1'b0;
  logic         rst;
  logic         read_i, write_i, resp_i;
  logic [31:0]  address_i;
  logic [255:0] line_i;
  logic [255:0] line_o;
  logic         resp_o;
  logic [63:0]  burst_i, burst_o;
  logic [31:0]  address_o;
  logic         read_o, write_o;

  int checks = 0;
  int failures = 0;
  int resp_cnt = 0;
  int resp_base;
  int lat;

  logic [255:0] rd_q[$];
  logic [63:0]  wr_q[$];
  logic [255:0] last_line;
  logic [63:0]  beats[4];
  logic [63:0]  dw[4];
  int           pat[7];

  cacheline_adapter dut (
    .clk       (clk),
    .rst       (rst),
    .read_i    (read_i),
    .write_i   (write_i),
    .address_i (address_i),
    .line_i    (line_i),
    .line_o    (line_o),
    .resp_o    (resp_o),
    .burst_i   (burst_i),
    .burst_o   (burst_o),
    .address_o (address_o),
    .read_o    (read_o),
    .write_o   (write_o),
    .resp_i    (resp_i)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one cycle; sample 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
    if (resp_o === 1'b1) resp_cnt++;
  endtask

  // Drives four contiguous read beats; leaves the bench in the DONE cycle.
  task automatic read_beats(input logic [63:0] b0, input logic [63:0] b1,
                            input logic [63:0] b2, input logic [63:0] b3);
    logic [63:0] bb[4];
    bb[0] = b0; bb[1] = b1; bb[2] = b2; bb[3] = b3;
    for (int k = 0; k < 4; k++) begin
      burst_i = bb[k];
      resp_i  = 1'b1;
      tick();
    end
    resp_i  = 1'b0;
    burst_i = '0;
  endtask

  initial begin
    rst = 1'b0; read_i = 0; write_i = 0; resp_i = 0;
    address_i = '0; line_i = '0; burst_i = '0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_read_o", read_o, 1'b0);
    chk("rst_write_o", write_o, 1'b0);
    chk("rst_resp_o", resp_o, 1'b0);
    chk("rst_address_o", address_o, 32'h0);
    chk("rst_burst_o", burst_o, 64'h0);
    chk("rst_line_o", line_o, 256'h0);
    rst = 1'b1;
    tick();

    // Read with contiguous beats
    beats[0] = 64'h1111_1111_1111_1111; beats[1] = 64'h2222_2222_2222_2222;
    beats[2] = 64'h3333_3333_3333_3333; beats[3] = 64'h4444_4444_4444_4444;
    rd_q.push_back({beats[3], beats[2], beats[1], beats[0]});
    address_i = 32'h0000_1234; read_i = 1'b1;
    resp_base = resp_cnt;
    tick();
    lat = 1;
    read_i = 1'b0;
    chk("rd1_read_o", read_o, 1'b1);
    chk("rd1_write_o", write_o, 1'b0);
    chk("rd1_address_o", address_o, 32'h0000_1220);
    read_beats(beats[0], beats[1], beats[2], beats[3]);
    lat += 4;
    chk("rd1_resp_o", resp_o, 1'b1);
    chk("rd1_latency", 256'(lat), 256'd5);
    chk("rd1_read_o_done", read_o, 1'b0);
    last_line = rd_q.pop_front();
    chk("rd1_line_o", line_o, last_line);
    tick();
    chk("rd1_resp_o_idle", resp_o, 1'b0);
    chk("rd1_resp_count", 256'(resp_cnt - resp_base), 256'd1);

    // Write with gaps; inputs change after acceptance
    dw[0] = 64'h0123_4567_89AB_CDEF; dw[1] = 64'hFEDC_BA98_7654_3210;
    dw[2] = 64'hA5A5_5A5A_C3C3_3C3C; dw[3] = 64'h0F0F_F0F0_1234_8765;
    for (int k = 0; k < 4; k++) wr_q.push_back(dw[k]);
    pat[0] = 1; pat[1] = 0; pat[2] = 0; pat[3] = 1; pat[4] = 1; pat[5] = 0; pat[6] = 1;
    line_i = {dw[3], dw[2], dw[1], dw[0]};
    address_i = 32'h0000_ABCD; write_i = 1'b1;
    tick();
    write_i = 1'b0;
    address_i = 32'hFFFF_FFFF;
    line_i = {4{64'hDEAD_BEEF_DEAD_BEEF}};
    for (int c = 0; c < 7; c++) begin
      resp_i = pat[c][0];
      chk($sformatf("wr_write_o_c%0d", c), write_o, 1'b1);
      chk($sformatf("wr_resp_o_c%0d", c), resp_o, 1'b0);
      chk($sformatf("wr_address_o_c%0d", c), address_o, 32'h0000_ABC0);
      if (wr_q.size() == 0) chk("wr_queue_underflow", 256'd0, 256'd1);
      else chk($sformatf("wr_burst_o_c%0d", c), burst_o, wr_q[0]);
      tick();
      if (pat[c] == 1 && wr_q.size() != 0) void'(wr_q.pop_front());
    end
    resp_i = 1'b0;
    chk("wr_resp_o", resp_o, 1'b1);
    chk("wr_write_o_done", write_o, 1'b0);
    chk("wr_beats_left", 256'(wr_q.size()), 256'd0);
    tick();
    chk("wr_resp_o_idle", resp_o, 1'b0);

    // Simultaneous read and write: write first, then read
    dw[0] = 64'hAAAA_0000_0000_0001; dw[1] = 64'hAAAA_0000_0000_0002;
    dw[2] = 64'hAAAA_0000_0000_0003; dw[3] = 64'hAAAA_0000_0000_0004;
    for (int k = 0; k < 4; k++) wr_q.push_back(dw[k]);
    line_i = {dw[3], dw[2], dw[1], dw[0]};
    address_i = 32'h2000_0047; read_i = 1'b1; write_i = 1'b1;
    resp_base = resp_cnt;
    tick();
    chk("sim_write_o", write_o, 1'b1);
    chk("sim_read_o", read_o, 1'b0);
    chk("sim_address_o", address_o, 32'h2000_0040);
    for (int k = 0; k < 4; k++) begin
      resp_i = 1'b1;
      if (wr_q.size() != 0) chk($sformatf("sim_burst_o_b%0d", k), burst_o, wr_q.pop_front());
      tick();
    end
    resp_i = 1'b0;
    chk("sim_resp_o_wr", resp_o, 1'b1);
    chk("sim_read_o_done", read_o, 1'b0);
    tick();
    write_i = 1'b0;
    chk("sim_read_o_idle", read_o, 1'b0);
    chk("sim_write_o_idle", write_o, 1'b0);
    beats[0] = 64'h5555_0000_0000_0000; beats[1] = 64'h6666_0000_0000_0000;
    beats[2] = 64'h7777_0000_0000_0000; beats[3] = 64'h8888_0000_0000_0000;
    rd_q.push_back({beats[3], beats[2], beats[1], beats[0]});
    tick();
    read_i = 1'b0;
    chk("sim_read_o_rd", read_o, 1'b1);
    read_beats(beats[0], beats[1], beats[2], beats[3]);
    chk("sim_resp_o_rd", resp_o, 1'b1);
    last_line = rd_q.pop_front();
    chk("sim_line_o", line_o, last_line);
    tick();
    chk("sim_resp_count", 256'(resp_cnt - resp_base), 256'd2);

    // Reset in the middle of a read
    address_i = 32'h0000_4000; read_i = 1'b1;
    tick();
    read_i = 1'b0;
    resp_base = resp_cnt;
    for (int k = 0; k < 2; k++) begin
      burst_i = 64'h9999_9999_9999_9990 + 64'(k);
      resp_i = 1'b1;
      tick();
    end
    resp_i = 1'b0;
    rst = 1'b0;
    #1;
    chk("rstmid_read_o", read_o, 1'b0);
    chk("rstmid_line_o", line_o, 256'h0);
    chk("rstmid_address_o", address_o, 32'h0);
    repeat (3) tick();
    chk("rstmid_no_resp", 256'(resp_cnt - resp_base), 256'd0);
    rst = 1'b1;
    tick();
    chk("rstmid_idle_read_o", read_o, 1'b0);
    beats[0] = 64'hC0DE_0000_0000_0001; beats[1] = 64'hC0DE_0000_0000_0002;
    beats[2] = 64'hC0DE_0000_0000_0003; beats[3] = 64'hC0DE_0000_0000_0004;
    rd_q.push_back({beats[3], beats[2], beats[1], beats[0]});
    address_i = 32'h0000_4010; read_i = 1'b1;
    tick();
    read_i = 1'b0;
    chk("rd2_read_o", read_o, 1'b1);
    chk("rd2_address_o", address_o, 32'h0000_4000);
    read_beats(beats[0], beats[1], beats[2], beats[3]);
    chk("rd2_resp_o", resp_o, 1'b1);
    last_line = rd_q.pop_front();
    chk("rd2_line_o", line_o, last_line);
    tick();

    // Stray resp_i while idle
    resp_base = resp_cnt;
    for (int c = 0; c < 3; c++) begin
      burst_i = 64'hBAD0_BAD0_BAD0_BAD0 + 64'($urandom_range(0, 255));
      resp_i = 1'b1;
      tick();
      chk($sformatf("stray_read_o_c%0d", c), read_o, 1'b0);
      chk($sformatf("stray_write_o_c%0d", c), write_o, 1'b0);
      chk($sformatf("stray_line_o_c%0d", c), line_o, last_line);
    end
    resp_i = 1'b0;
    tick();
    chk("stray_no_resp", 256'(resp_cnt - resp_base), 256'd0);
    chk("scoreboard_empty", 256'(rd_q.size() + wr_q.size()), 256'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
